div_iter_unit: RTL

DIV_ITER_UNIT -- requirements
Module: div_iter_unit

---
 rtl/div_iter_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div_iter_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// then a separate sign-fix cycle, so every operation takes the same fixed latency.
module div_iter_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [1:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        div_in_valid,
   output logic        div_in_ready,
   output logic [63:0] div_result,
   output logic        div_out_valid,
   input  logic        div_out_ready
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic        q_sign_q, q_sign_d;
   logic        r_sign_q, r_sign_d;
   logic [63:0] result_q, result_d;

   logic        is_signed;
   logic [31:0] abs_dvd, abs_dvs;
   logic [32:0] rem_shift, diff;
   logic [31:0] q_fix, r_fix;

   always_comb begin
      // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch can be inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      q_sign_d = q_sign_q;
      r_sign_d = r_sign_q;
      result_d = result_q;

      is_signed = div_op[0];
      abs_dvd   = (is_signed && dividend[31]) ? -dividend : dividend;
      abs_dvs   = (is_signed && divisor[31])  ? -divisor  : divisor;

      // rem_shift < 2*divisor, so the 33-bit difference never wraps and bit 32 is its sign.
      rem_shift = {rem_q, dvd_q[31]};
      diff      = rem_shift - {1'b0, dvs_q};
      q_fix     = q_sign_q ? -quo_q : quo_q;
      r_fix     = r_sign_q ? -rem_q : rem_q;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (div_in_valid) begin
                  dvd_d    = abs_dvd;
                  dvs_d    = abs_dvs;
                  rem_d    = '0;
                  quo_d    = '0;
                  cnt_d    = '0;
                  q_sign_d = is_signed & (dividend[31] ^ divisor[31]);
                  r_sign_d = is_signed & dividend[31];
                  state_d  = ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Counts 0..31 are the 32 radix-2 steps; count 32 applies the sign fix and latches.
               if (cnt_q == 6'd32) begin
                  result_d = {r_fix, q_fix};
                  state_d  = ST_DONE;
               end else begin
                  dvd_d = {dvd_q[30:0], 1'b0};
                  if (!diff[32]) begin
                     rem_d = diff[31:0];
                     quo_d = {quo_q[30:0], 1'b1};
                  end else begin
                     rem_d = rem_shift[31:0];
                     quo_d = {quo_q[30:0], 1'b0};
                  end
                  cnt_d = cnt_q + 6'd1;
               end
            end
            ST_DONE: begin
               if (div_out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: flops use non-blocking '<='; only control state and the visible result are reset, datapath registers are reloaded on every accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         q_sign_q <= 1'b0;
         r_sign_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         q_sign_q <= q_sign_d;
         r_sign_q <= r_sign_d;
      end
   end

   always_ff @(posedge clk) begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
   end

   assign div_in_ready  = (state_q == ST_IDLE);
   assign div_out_valid = (state_q == ST_DONE);
   assign div_result    = result_q;

endmodule
